// File: rtl/div_unit.sv
// div_unit: multi-cycle 32-bit restoring divider for DIV/DIVU in the EX stage.
// One quotient bit per cycle. Result is {remainder, quotient}, valid while ready=1.
module div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        annul,
  output logic [63:0] result,
  output logic        ready,
  output logic        stop_req
);

  typedef enum logic [1:0] {IDLE, BYZERO, RUN, DONE} state_t;

  state_t      state_reg, state_next;
  logic [32:0] rem_reg;      // partial remainder
  logic [31:0] quo_reg;      // dividend bits shifting out, quotient bits shifting in
  logic [31:0] dvs_reg;      // divisor magnitude
  logic [5:0]  cnt_reg;
  logic        sgn_reg;      // latched signed_div
  logic        a_neg_reg;    // dividend sign
  logic        b_neg_reg;    // divisor sign

  logic [31:0] a_mag, b_mag;
  logic [32:0] shifted, diff, rem_step;
  logic        ge;
  logic [31:0] quo_step, q_fix, r_fix;

  // Operand magnitudes for the signed case; raw operands for DIVU.
  assign a_mag = (signed_div && dividend[31]) ? -dividend : dividend;
  assign b_mag = (signed_div && divisor[31])  ? -divisor  : divisor;

  // One restoring step. rem_reg[32] set would mean the shifted value exceeds any
  // 32-bit divisor, so it forces the subtract to be taken.
  assign shifted  = {rem_reg[31:0], quo_reg[31]};
  assign diff     = shifted - {1'b0, dvs_reg};
  assign ge       = rem_reg[32] | ~diff[32];
  assign rem_step = ge ? diff : shifted;
  assign quo_step = {quo_reg[30:0], ge};

  // Sign fix-up applied to the final step; modulo-2^32 so MIN/-1 wraps to MIN.
  assign q_fix = (sgn_reg && (a_neg_reg ^ b_neg_reg)) ? -quo_step : quo_step;
  assign r_fix = (sgn_reg && a_neg_reg) ? -rem_step[31:0] : rem_step[31:0];

  // Stall the EX stage while a request is outstanding and not yet answered.
  assign stop_req = start & ~ready & ~annul & ~reset;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic; annul wins over start everywhere.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start && !annul) state_next = (divisor == 32'h0) ? BYZERO : RUN;
      end
      BYZERO: begin
        state_next = annul ? IDLE : DONE;
      end
      RUN: begin
        if (annul || !start)          state_next = IDLE;
        else if (cnt_reg == 6'd31)    state_next = DONE;
      end
      DONE: begin
        if (annul || !start) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch operands on entry to RUN, then iterate.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_reg   <= 33'h0;
      quo_reg   <= 32'h0;
      dvs_reg   <= 32'h0;
      cnt_reg   <= 6'd0;
      sgn_reg   <= 1'b0;
      a_neg_reg <= 1'b0;
      b_neg_reg <= 1'b0;
    end else if (state_reg == IDLE && state_next == RUN) begin
      rem_reg   <= 33'h0;
      quo_reg   <= a_mag;
      dvs_reg   <= b_mag;
      cnt_reg   <= 6'd0;
      sgn_reg   <= signed_div;
      a_neg_reg <= dividend[31];
      b_neg_reg <= divisor[31];
    end else if (state_reg == RUN) begin
      rem_reg <= rem_step;
      quo_reg <= quo_step;
      cnt_reg <= cnt_reg + 6'd1;
    end
  end

  // Registered outputs: result captured on the final step, cleared outside DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      result <= 64'h0;
      ready  <= 1'b0;
    end else begin
      ready <= (state_next == DONE);
      if (state_next != DONE)
        result <= 64'h0;
      else if (state_reg == RUN)
        result <= {r_fix, q_fix};
      else if (state_reg == BYZERO)
        result <= 64'h0;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed and randomised checks of div_unit latency, results and control.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset, start, signed_div, annul;
  logic [31:0] dividend, divisor;
  logic [63:0] result;
  logic        ready, stop_req;

  int n_vec = 0;
  int n_err = 0;

  div_unit dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .signed_div (signed_div),
    .dividend   (dividend),
    .divisor    (divisor),
    .annul      (annul),
    .result     (result),
    .ready      (ready),
    .stop_req   (stop_req)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  // Independent reference: language division with the overflow and zero cases pinned.
  function automatic logic [63:0] ref_div(input logic sd, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic [31:0] q, r;
    sa = a;
    sb = b;
    if (b == 32'h0) return 64'h0;
    if (sd) begin
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Run one divide with start held, check latency, stop_req, result, hold and release.
  task automatic do_div(input string tag, input logic sd, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] want, input int lat);
    int k;
    @(negedge clk);
    signed_div = sd; dividend = a; divisor = b; start = 1'b1;
    #1;
    chk({tag, ".stop0"}, 64'(stop_req), 64'd1);
    k = 0;
    while (!ready && k < 60) begin
      @(negedge clk);
      k++;
      if (k == lat - 1) chk({tag, ".stop_last"}, 64'(stop_req), 64'd1);
    end
    chk({tag, ".latency"}, 64'(k), 64'(lat));
    chk({tag, ".stop_rdy"}, 64'(stop_req), 64'd0);
    chk({tag, ".result"}, result, want);
    @(negedge clk);
    chk({tag, ".hold_rdy"}, 64'(ready), 64'd1);
    chk({tag, ".hold_res"}, result, want);
    start = 1'b0;
    @(negedge clk);
    chk({tag, ".drop_rdy"}, 64'(ready), 64'd0);
    chk({tag, ".drop_res"}, result, 64'h0);
    $display("div %s sd=%0d %h / %h -> %h", tag, sd, a, b, result);
  endtask

  initial begin
    int seen;
    logic [31:0] ra, rb;
    logic        rs;
    reset = 1'b1; start = 1'b0; signed_div = 1'b0; annul = 1'b0;
    dividend = 32'h0; divisor = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst.ready", 64'(ready), 64'd0);
    chk("rst.result", result, 64'h0);
    chk("rst.stop", 64'(stop_req), 64'd0);
    reset = 1'b0;

    do_div("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
    do_div("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'h2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33);
    do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}, 33);
    do_div("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 33);
    do_div("divu_min_max", 1'b0, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'h0}, 33);
    do_div("div_by_zero", 1'b1, 32'd1234, 32'd0, 64'h0, 2);

    // Annul mid-run: the operation must never report ready.
    @(negedge clk);
    signed_div = 1'b0; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
    repeat (10) @(negedge clk);
    annul = 1'b1;
    #1;
    chk("annul.stop", 64'(stop_req), 64'd0);
    chk("annul.ready", 64'(ready), 64'd0);
    @(negedge clk);
    annul = 1'b0; start = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready) seen = 1;
    end
    chk("annul.no_ready", 64'(seen), 64'd0);
    $display("annul at cycle 10 of RUN, ready seen=%0d", seen);
    do_div("after_annul", 1'b0, 32'hFFFFFFFF, 32'h10, {32'hF, 32'h0FFFFFFF}, 33);

    // Reset mid-run.
    @(negedge clk);
    signed_div = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst.ready", 64'(ready), 64'd0);
    chk("midrst.result", result, 64'h0);
    chk("midrst.stop", 64'(stop_req), 64'd0);
    $display("reset at cycle 20 of RUN, ready=%0d result=%h", ready, result);
    reset = 1'b0; start = 1'b0;
    do_div("after_reset", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);

    // Random operands against the reference model.
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = (i % 4 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
      if (i == 5) rb = 32'hFFFFFFF0;
      rs = (i % 2 == 1);
      do_div($sformatf("rand%0d", i), rs, ra, rb, ref_div(rs, ra, rb), (rb == 32'h0) ? 2 : 33);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
